// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer feeding decode format scan; define FETCH_QUEUE_BYPASS_EN to let an empty queue forward fetch straight to the output registers
module fetch_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 8,
    parameter int queueIndexWidth         = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               fetchValid_i,
    output logic                               fetchReady_o,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               flush_i,
    input  logic                               stall_i,
    output logic                               outputEnable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic [queueIndexWidth:0]           occupancy_o
);
    typedef struct packed {
        logic [instructionWidth-1:0] ins;
        logic [addressWidth-1:0]     adr;
        logic [PidSize-1:0]          pid;
        logic [TidSize-1:0]          tid;
    } entry_t;

    localparam logic [queueIndexWidth:0] full_count = queueDepth[queueIndexWidth:0];

    entry_t                               mem_q [queueDepth];
    entry_t                               mem_d [queueDepth];
    logic [queueIndexWidth-1:0]           head_q, head_d, tail_q, tail_d;
    logic [queueIndexWidth:0]             count_q, count_d;
    logic [instructionCounterWidth-1:0]   ctr_q, ctr_d, id_q, id_d;
    entry_t                               out_q, out_d;
    logic                                 oe_q, oe_d;
    logic                                 push, pop, bypass, enq;
    entry_t                               fetch_e;

    assign fetch_e = '{ins: instruction_i, adr: instructionAddress_i,
                       pid: instructionPid_i, tid: instructionTid_i};

    // ready depends on the stored count alone so fetch never sees a stall-dependent path
    assign fetchReady_o = count_q != full_count;

    // qualify push/pop/bypass; flush overrides everything on the same edge
    always_comb begin
        push = fetchValid_i && fetchReady_o && !flush_i;
        pop  = !stall_i && count_q != '0 && !flush_i;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = fetchValid_i && !stall_i && !flush_i && count_q == '0;
`else
        bypass = 1'b0;
`endif
        enq = push && !bypass;
    end

    // queue storage, pointers and count; a bypassed fetch never enters storage
    always_comb begin
        mem_d = mem_q;
        if (enq)
            mem_d[tail_q] = fetch_e;
        head_d  = flush_i ? '0 : (pop ? head_q + 1'b1 : head_q);
        tail_d  = flush_i ? '0 : (enq ? tail_q + 1'b1 : tail_q);
        count_d = flush_i ? '0 : count_q + {{queueIndexWidth{1'b0}}, enq} - {{queueIndexWidth{1'b0}}, pop};
    end

    // output bundle: pop from head first (FIFO order), else bypass, else drop valid when decode is ready
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        id_d  = id_q;
        ctr_d = ctr_q;
        if (flush_i) begin
            oe_d = 1'b0;
        end else if (pop || bypass) begin
            out_d = pop ? mem_q[head_q] : fetch_e;
            oe_d  = 1'b1;
            id_d  = ctr_q;
            ctr_d = ctr_q + 1'b1;
        end else if (!stall_i) begin
            oe_d = 1'b0;
        end
    end

    // control and output state; counter survives flush so IDs stay unique
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ctr_q   <= '0;
            id_q    <= '0;
            out_q   <= '0;
            oe_q    <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ctr_q   <= ctr_d;
            id_q    <= id_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
        end
    end

    // entry storage needs no reset; only pointers/count define validity
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

    assign outputEnable_o       = oe_q;
    assign instruction_o        = out_q.ins;
    assign instructionAddress_o = out_q.adr;
    assign instructionPid_o     = out_q.pid;
    assign instructionTid_o     = out_q.tid;
    assign instructionMajId_o   = id_q;
    assign occupancy_o          = count_q;
endmodule
